// File: rtl/count_monitor.sv
// count_monitor
// Passive checker for a WIDTH-bit up/down counter. Samples q each enabled
// clock, classifies the step against the previous sample (UP, DOWN, HOLD,
// BAD), recovers the counting direction and flags wraps, stalls and illegal
// steps. All outputs are registered.
//
// Ports:
//   clk        rising-edge clock shared with the counter
//   rst_n      asynchronous active-low reset
//   en         sample enable; when 0 no state changes, pulses go low
//   clr        synchronous clear of err_cnt (acts regardless of en)
//   q          observed counter value
//   dir        recovered direction, 1 = up, 0 = down
//   dir_valid  dir is trustworthy (tracking states only)
//   dir_change one-cycle pulse on up/down reversal
//   wrap       one-cycle pulse on a legal wrap (max->0 up, 0->max down)
//   stall      level, last sample equal to previous while tracking
//   step_err   one-cycle pulse on an illegal step
//   err_cnt    saturating count of illegal steps
//
// state      | meaning
// -----------+--------------------------------------------------------
// ACQUIRE    | no direction yet; waiting for first legal UP/DOWN step
// TRACK_UP   | counter observed counting up
// TRACK_DOWN | counter observed counting down
// FAULT      | last step was illegal; re-lock on next UP/DOWN step
module count_monitor #(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] q,
  output logic             dir,
  output logic             dir_valid,
  output logic             dir_change,
  output logic             wrap,
  output logic             stall,
  output logic             step_err,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    ACQUIRE    = 2'd0,
    TRACK_UP   = 2'd1,
    TRACK_DOWN = 2'd2,
    FAULT      = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] prev;
  logic             have_prev;

  logic             dir_nxt, dir_valid_nxt, dir_change_nxt;
  logic             wrap_nxt, stall_nxt, step_err_nxt;
  logic [ERR_W-1:0] err_cnt_nxt;

  logic [WIDTH-1:0] delta;
  logic             step_up, step_down, step_hold, step_bad;
  logic             tracking;

  // Modular difference makes wraps look like ordinary +1/-1 steps.
  assign delta     = q - prev;
  assign step_up   = (delta == WIDTH'(1));
  assign step_down = (delta == {WIDTH{1'b1}});
  assign step_hold = (delta == '0);
  assign step_bad  = !(step_up || step_down || step_hold);
  assign tracking  = (state == TRACK_UP) || (state == TRACK_DOWN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ACQUIRE;
      prev       <= '0;
      have_prev  <= 1'b0;
      dir        <= 1'b0;
      dir_valid  <= 1'b0;
      dir_change <= 1'b0;
      wrap       <= 1'b0;
      stall      <= 1'b0;
      step_err   <= 1'b0;
      err_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      dir        <= dir_nxt;
      dir_valid  <= dir_valid_nxt;
      dir_change <= dir_change_nxt;
      wrap       <= wrap_nxt;
      stall      <= stall_nxt;
      step_err   <= step_err_nxt;
      err_cnt    <= err_cnt_nxt;
      if (en) begin
        prev      <= q;
        have_prev <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    dir_nxt        = dir;
    dir_valid_nxt  = dir_valid;
    dir_change_nxt = 1'b0;
    wrap_nxt       = 1'b0;
    stall_nxt      = stall;
    step_err_nxt   = 1'b0;

    if (en) begin
      // Without a previous sample there is nothing to classify.
      if (have_prev) begin
        case (state)
          ACQUIRE: begin
            if (step_up)        state_nxt = TRACK_UP;
            else if (step_down) state_nxt = TRACK_DOWN;
          end
          TRACK_UP: begin
            if (step_down) begin
              state_nxt      = TRACK_DOWN;
              dir_change_nxt = 1'b1;
            end else if (step_bad) begin
              state_nxt = FAULT;
            end
          end
          TRACK_DOWN: begin
            if (step_up) begin
              state_nxt      = TRACK_UP;
              dir_change_nxt = 1'b1;
            end else if (step_bad) begin
              state_nxt = FAULT;
            end
          end
          FAULT: begin
            // Re-lock is not a reversal, so no dir_change here.
            if (step_up)        state_nxt = TRACK_UP;
            else if (step_down) state_nxt = TRACK_DOWN;
          end
          default: state_nxt = ACQUIRE;
        endcase

        step_err_nxt = step_bad;
        wrap_nxt     = (step_up && (prev == {WIDTH{1'b1}})) ||
                       (step_down && (prev == '0));
      end

      dir_valid_nxt = (state_nxt == TRACK_UP) || (state_nxt == TRACK_DOWN);
      stall_nxt     = have_prev && tracking && step_hold;
      if (state_nxt == TRACK_UP)   dir_nxt = 1'b1;
      if (state_nxt == TRACK_DOWN) dir_nxt = 1'b0;
    end

    // A clear coinciding with an illegal step still records that step.
    if (clr)
      err_cnt_nxt = {{(ERR_W-1){1'b0}}, step_err_nxt};
    else if (step_err_nxt && (err_cnt != {ERR_W{1'b1}}))
      err_cnt_nxt = err_cnt + ERR_W'(1);
    else
      err_cnt_nxt = err_cnt;
  end

endmodule

// File: tb/tb_count_monitor.sv
module tb_count_monitor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       clr;
  logic [3:0] q;

  logic       dir, dir_valid, dir_change, wrap, stall, step_err;
  logic [7:0] err_cnt;
  logic       dir2, dir_valid2, dir_change2, wrap2, stall2, step_err2;
  logic [1:0] err_cnt2;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  count_monitor #(.WIDTH(4), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .q(q),
    .dir(dir), .dir_valid(dir_valid), .dir_change(dir_change),
    .wrap(wrap), .stall(stall), .step_err(step_err), .err_cnt(err_cnt)
  );

  count_monitor #(.WIDTH(4), .ERR_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .q(q),
    .dir(dir2), .dir_valid(dir_valid2), .dir_change(dir_change2),
    .wrap(wrap2), .stall(stall2), .step_err(step_err2), .err_cnt(err_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are then sampled
  // 1 time unit after the next rising edge.
  task automatic apply(input int v);
    q = 4'(v);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; q = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_flags", {dir, dir_valid, dir_change, wrap, stall, step_err}, 6'b0);
    chk("reset_err",   err_cnt, 0);
    rst_n = 1'b1;
    en    = 1'b1;

    // Acquire on 0,1,2,3
    apply(0);
    chk("acq_first_valid", dir_valid, 0);
    apply(1);
    chk("acq_valid_after_1", {dir, dir_valid, dir_change}, 3'b110);
    apply(2);
    apply(3);
    chk("acq_track_3", {dir, dir_valid, dir_change, err_cnt}, {3'b110, 8'd0});

    // Stall while tracking up: 4,5,5,5,6
    apply(4);
    apply(5);
    chk("stall_before", stall, 0);
    apply(5);
    chk("stall_1", {stall, dir, dir_valid}, 3'b111);
    apply(5);
    chk("stall_2", {stall, dir, dir_valid}, 3'b111);
    apply(6);
    chk("stall_end", {stall, dir, dir_change}, 3'b010);

    // Up wrap 13,14,15,0,1
    for (int v = 7; v <= 13; v++) apply(v);
    apply(14);
    apply(15);
    chk("wrap_up_pre", wrap, 0);
    apply(0);
    chk("wrap_up", {wrap, dir_valid}, 2'b11);
    apply(1);
    chk("wrap_up_post", {wrap, dir_valid}, 2'b01);

    // Reversal at 7 -> 6
    for (int v = 2; v <= 7; v++) apply(v);
    apply(6);
    chk("rev_down", {dir_change, dir, dir_valid}, 3'b101);
    apply(5);
    chk("rev_down_once", {dir_change, dir}, 2'b00);

    // Down wrap 1,0,15
    for (int v = 4; v >= 1; v--) apply(v);
    apply(0);
    chk("wrap_dn_pre", wrap, 0);
    apply(15);
    chk("wrap_dn", {wrap, dir, dir_valid}, 3'b101);
    apply(14);
    chk("wrap_dn_post", wrap, 0);

    // Down to 3, up to 4, then illegal jump to 9 and re-lock at 10
    for (int v = 13; v >= 3; v--) apply(v);
    apply(4);
    chk("rev_up", {dir_change, dir}, 2'b11);
    apply(9);
    chk("fault_enter", {step_err, dir_valid, dir}, 3'b101);
    chk("fault_err",     err_cnt,  1);
    chk("fault_err_sat", err_cnt2, 1);
    apply(10);
    chk("fault_exit", {step_err, dir_valid, dir, dir_change}, 4'b0110);
    chk("fault_exit_err", err_cnt, 1);

    // Six back-to-back illegal steps: 10->0->5->10->15->4->9
    apply(0);
    chk("bad1", {step_err, dir_valid, err_cnt, err_cnt2}, {2'b10, 8'd2, 2'd2});
    apply(5);
    chk("bad2", {step_err, err_cnt, err_cnt2}, {1'b1, 8'd3, 2'd3});
    apply(10);
    chk("bad3", {step_err, err_cnt, err_cnt2}, {1'b1, 8'd4, 2'd3});
    apply(15);
    chk("bad4", {step_err, err_cnt, err_cnt2}, {1'b1, 8'd5, 2'd3});
    apply(4);
    chk("bad5", {step_err, err_cnt, err_cnt2}, {1'b1, 8'd6, 2'd3});
    apply(9);
    chk("bad6", {step_err, dir_valid, err_cnt, err_cnt2}, {2'b10, 8'd7, 2'd3});

    // clr together with an illegal step (9 -> 14)
    clr = 1'b1;
    apply(14);
    clr = 1'b0;
    chk("clr_bad", {step_err, err_cnt, err_cnt2}, {1'b1, 8'd1, 2'd1});

    // en low: an illegal value is ignored, pulses drop, clr still acts
    en = 1'b0;
    apply(0);
    chk("en_low_hold", {step_err, wrap, dir_valid, err_cnt}, {3'b000, 8'd1});
    clr = 1'b1;
    apply(0);
    clr = 1'b0;
    chk("en_low_clr", {err_cnt, err_cnt2}, {8'd0, 2'd0});
    en = 1'b1;
    apply(15);
    chk("relock_up", {dir_valid, dir, dir_change, wrap, step_err}, 5'b11000);
    apply(0);
    chk("relock_wrap", {wrap, dir_valid}, 2'b11);
    apply(1);
    apply(7);
    chk("pre_rst_bad", {step_err, err_cnt}, {1'b1, 8'd1});

    // Asynchronous reset between edges
    rst_n = 1'b0;
    #2;
    chk("async_rst_flags", {dir, dir_valid, dir_change, wrap, stall, step_err}, 6'b0);
    chk("async_rst_err", {err_cnt, err_cnt2}, 10'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply(9);
    chk("post_rst_first", {step_err, dir_valid, wrap}, 3'b000);
    apply(10);
    chk("post_rst_track", {dir_valid, dir, step_err, err_cnt}, {3'b110, 8'd0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/count_monitor.md
# count_monitor

Passive checker that samples the output of the 4-bit up/down counter each clock and reconstructs what the counter was told to do. It recovers the counting direction, flags wrap-around, detects illegal steps, and keeps a saturating error tally. It sits beside `counter4` on the same clock and reads `q` only. It is the receiving end of the counter's output interface and drives no counter input.

## Interface
- `WIDTH`, 4, width of the observed count (must be ≥ 2)
- `ERR_W`, 8, width of the error counter
- `clk` input 1, rising-edge clock shared with the counter
- `rst_n` input 1, reset: asynchronous, active-low (one clock domain)
- `en` input 1, sample enable; when 0 no state changes
- `clr` input 1, synchronous clear of `err_cnt`
- `q` input WIDTH, observed counter value
- `dir` output 1, recovered direction: 1 = up, 0 = down
- `dir_valid` output 1, `dir` is trustworthy (state TRACK_UP/TRACK_DOWN)
- `dir_change` output 1, one-cycle pulse on up↔down reversal
- `wrap` output 1, one-cycle pulse on legal wrap (max→0 up, 0→max down)
- `stall` output 1, level: last sample equal to previous while tracking
- `step_err` output 1, one-cycle pulse on illegal step
- `err_cnt` output ERR_W, saturating count of illegal steps

## Operation
- Registers: `prev` (WIDTH), `have_prev` (1), state (2 bits), plus all outputs. All outputs are registered.
- Step classification on each enabled edge, with `have_prev` = 1. `delta = (q - prev) mod 2^WIDTH`:
  - delta = 1 → UP
  - delta = 2^WIDTH-1 → DOWN
  - delta = 0 → HOLD
  - otherwise → BAD
- `prev <= q` and `have_prev <= 1` on every enabled edge.
- States: ACQUIRE, TRACK_UP, TRACK_DOWN, FAULT.
- ACQUIRE:
  - First enabled sample only loads `prev`.
  - Afterwards UP → TRACK_UP and DOWN → TRACK_DOWN.
  - HOLD stays in ACQUIRE.
  - BAD stays in ACQUIRE and raises `step_err`.
- TRACK_UP / TRACK_DOWN:
  - Same-direction step stays in the current state.
  - Opposite step moves to the other TRACK state and pulses `dir_change`.
  - HOLD stays in the current state with `stall` = 1.
  - BAD → FAULT and pulses `step_err`.
- FAULT:
  - UP/DOWN → matching TRACK state, with no `dir_change` pulse.
  - HOLD stays in FAULT.
  - BAD stays in FAULT and pulses `step_err`.
- Output rules:
  - `dir_valid` = 1 only in the TRACK states.
  - `dir` holds its last tracked value in ACQUIRE and FAULT.
  - `stall` is 0 outside the TRACK states.
  - `wrap` pulses on UP with `prev` = all-ones, or on DOWN with `prev` = 0, in any state.
- `err_cnt` behaviour:
  - Increments on each `step_err` and saturates at 2^ERR_W-1.
  - `clr` zeroes it.
  - `clr` and BAD in the same cycle gives `err_cnt` = 1.
- `en` = 0 behaviour:
  - `prev`, state, `dir`, `dir_valid`, `stall` and `err_cnt` hold.
  - Pulse outputs go to 0.
  - `clr` still acts.

## Timing
- Reset values (async, while `rst_n` = 0): state = ACQUIRE, `have_prev` = 0, `prev` = 0, `dir` = 0, `dir_valid` = 0, `dir_change` = 0, `wrap` = 0, `stall` = 0, `step_err` = 0, `err_cnt` = 0.
- Latency: a `q` value sampled at edge N is reflected on the outputs after edge N. Direction is therefore valid at the earliest after the second enabled edge following reset.
- Pulses (`dir_change`, `wrap`, `step_err`) are high for exactly one cycle per event. Back-to-back events keep the pulse high on consecutive cycles.
- Reset asserted mid-track returns the block to ACQUIRE immediately. The first post-reset sample is not compared against any pre-reset value.
- The block is in the counter's clock domain, and `q` is sampled on the same edge the counter updates. No synchroniser is required.

## Test plan
- Reset release, then `q` = 0,1,2,3 → `dir_valid` rises after the edge sampling 1, with `dir` = 1. `err_cnt` = 0, and no `dir_change`.
- Up count 13,14,15,0,1 → `wrap` is a single one-cycle pulse after the edge sampling 0, and `dir_valid` stays 1.
- Up count to 7, then 6,5 → `dir_change` pulses once after 6 is sampled, `dir` = 0, and down wrap 1,0,15 pulses `wrap` on 15.
- While tracking, `q` = 5,5,5,6 → `stall` = 1 for two cycles, then 0, with `dir` unchanged.
- `q` = 3,4,9,10 → after sampling 9: `step_err` pulse, `err_cnt` = 1, `dir_valid` = 0 (FAULT). After sampling 10: TRACK_UP, `dir_valid` = 1, no `dir_change`.
- `ERR_W` = 2 with six BAD steps → `err_cnt` saturates at 3. `clr` concurrent with a BAD step → `err_cnt` = 1. `rst_n` low mid-stream → all outputs return to their reset values immediately, without waiting for a clock edge.
